// File: rtl/dynaq_model_replay_unit_if.sv
// Controller <-> model/replay unit signal bundle for dynaq_model_replay_unit.
interface dynaq_model_replay_unit_if #(
  parameter int LOCATION_WIDTH     = 4,
  parameter int ACTION_WIDTH       = 2,
  parameter int HISTORY_ADDR_WIDTH = 6
);
  logic                          history_clear;
  logic                          w_history_table_enable;
  logic [LOCATION_WIDTH-1:0]     cur_location;
  logic [ACTION_WIDTH-1:0]       cur_action;
  logic                          random_remember_en;
  logic                          w_remember_time_enable;
  logic                          w_remember_time_select;
  logic [LOCATION_WIDTH-1:0]     remember_location;
  logic [ACTION_WIDTH-1:0]       remember_action;
  logic                          remember_valid;
  logic                          remember_done;
  logic [HISTORY_ADDR_WIDTH:0]   history_count;
  logic                          history_full;

  modport master (
    output history_clear, w_history_table_enable, cur_location, cur_action,
           random_remember_en, w_remember_time_enable, w_remember_time_select,
    input  remember_location, remember_action, remember_valid, remember_done,
           history_count, history_full
  );

  modport slave (
    input  history_clear, w_history_table_enable, cur_location, cur_action,
           random_remember_en, w_remember_time_enable, w_remember_time_select,
    output remember_location, remember_action, remember_valid, remember_done,
           history_count, history_full
  );
endinterface

// File: rtl/dynaq_model_replay_unit.sv
// Dyna-Q model memory: records visited (location, action) pairs and replays them for planning.
// Optional: DYNAQ_REPLAY_LFSR_FREERUN_EN makes the LFSR advance every clock.
module dynaq_model_replay_unit #(
  parameter int          LOCATION_WIDTH     = 4,
  parameter int          ACTION_WIDTH       = 2,
  parameter int          HISTORY_DEPTH      = 64,
  parameter int          HISTORY_ADDR_WIDTH = 6,
  parameter int          PLANNING_STEPS     = 5,
  parameter logic [15:0] LFSR_SEED          = 16'hACE1
) (
  input logic clk,
  input logic reset,
  dynaq_model_replay_unit_if.slave bus
);
  localparam int PW = LOCATION_WIDTH + ACTION_WIDTH;
  localparam int CW = HISTORY_ADDR_WIDTH + 1;

  logic [PW-1:0]                 r_list [HISTORY_DEPTH];
  logic [(2**PW)-1:0]            r_visited;
  logic [CW-1:0]                 r_count;
  logic [15:0]                   r_lfsr;
  logic [LOCATION_WIDTH-1:0]     r_loc;
  logic [ACTION_WIDTH-1:0]       r_act;
  logic                          r_valid;
  logic [7:0]                    r_cnt;

  logic [PW-1:0]                 w_pair;
  logic                          w_full;
  logic                          w_rec_ok;
  logic [15:0]                   w_lfsr_next;
  logic [CW-1:0]                 w_r;
  logic [CW-1:0]                 w_wrap;
  logic [HISTORY_ADDR_WIDTH-1:0] w_sel;

  assign w_pair      = {bus.cur_location, bus.cur_action};
  assign w_full      = (r_count == CW'(HISTORY_DEPTH));
  assign w_rec_ok    = bus.w_history_table_enable && !bus.history_clear &&
                       !r_visited[w_pair] && !w_full;
  assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

  // Fold r into [0, n): one subtraction, then clamp to the last entry.
  always_comb begin
    w_r    = {1'b0, r_lfsr[HISTORY_ADDR_WIDTH-1:0]};
    w_wrap = w_r - r_count;
    w_sel  = '0;
    if (w_r < r_count)         w_sel = w_r[HISTORY_ADDR_WIDTH-1:0];
    else if (w_wrap < r_count) w_sel = w_wrap[HISTORY_ADDR_WIDTH-1:0];
    else                       w_sel = HISTORY_ADDR_WIDTH'(r_count - CW'(1));
  end

  always_ff @(posedge clk) begin
    if (w_rec_ok) r_list[r_count[HISTORY_ADDR_WIDTH-1:0]] <= w_pair;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_visited <= '0;
      r_count   <= '0;
      r_lfsr    <= LFSR_SEED;
      r_loc     <= '0;
      r_act     <= '0;
      r_valid   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (bus.history_clear) begin
        r_visited <= '0;
        r_count   <= '0;
      end else if (w_rec_ok) begin
        r_visited[w_pair] <= 1'b1;
        r_count           <= r_count + CW'(1);
      end

`ifdef DYNAQ_REPLAY_LFSR_FREERUN_EN
      r_lfsr <= w_lfsr_next;
`else
      if (bus.random_remember_en) r_lfsr <= w_lfsr_next;
`endif

      if (bus.random_remember_en) begin
        if (r_count == '0) begin
          r_valid <= 1'b0;
        end else begin
          {r_loc, r_act} <= r_list[w_sel];
          r_valid        <= 1'b1;
        end
      end

      if (bus.w_remember_time_enable) begin
        if (!bus.w_remember_time_select) r_cnt <= 8'(PLANNING_STEPS);
        else if (r_cnt != 8'd0)          r_cnt <= r_cnt - 8'd1;
      end
    end
  end

  assign bus.remember_location = r_loc;
  assign bus.remember_action   = r_act;
  assign bus.remember_valid    = r_valid;
  assign bus.remember_done     = (r_cnt <= 8'd1);
  assign bus.history_count     = r_count;
  assign bus.history_full      = w_full;
endmodule
